i2c_codec_responder: RTL and testbench
======================================

I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, is the 7-bit device address this block responds to.
REQ-002 Parameter NREG, default 16, is the number of 9-bit control registers held.
REQ-003 i_clk  in  1  system clock; at least 8x the SCL frequency.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_scl  in  1  I2C clock, asynchronous to i_clk.
REQ-006 i_sda  in  1  I2C data as read from the bus, asynchronous to i_clk.
REQ-007 o_sda_oe  out  1  1 means pull SDA low; 0 means release SDA.
REQ-008 o_wr_valid  out  1  one-cycle pulse marking a committed register write.
REQ-009 o_wr_addr  out  7  register address of the last committed write.
REQ-010 o_wr_data  out  9  data of the last committed write.
REQ-011 i_rd_addr  in  4  register-file read index.
REQ-012 o_rd_data  out  9  combinational read of register i_rd_addr.
REQ-013 o_busy  out  1  high from START detection until STOP detection.

Function
REQ-014 i_scl and i_sda SHALL each pass through a 2-flop synchronizer, then a 1-flop edge-detect stage.
REQ-015 START SHALL be detected when SDA falls while SCL is high; STOP SHALL be detected when SDA rises while SCL is high.
REQ-016 The FSM SHALL have these states: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-017 Data bits SHALL be sampled on the synchronized SCL rising edge, MSB first.
REQ-018 A START in any state SHALL enter ADDR with the bit counter cleared; any partial frame SHALL be discarded, which covers repeated START.
REQ-019 A STOP in any state SHALL enter IDLE and discard any partial frame.
REQ-020 In ADDR, after 8 bits: if addr[7:1]==DEV_ADDR and R/W==0, go to ACK_A; otherwise go to IGNORE without driving SDA.
REQ-021 ACK drive timing:
- o_sda_oe SHALL rise on the SCL falling edge that ends bit 8.
- o_sda_oe SHALL fall on the SCL falling edge that ends the ACK clock.
REQ-022 Byte 1 SHALL carry {reg_addr[6:0], data[8]}; byte 2 SHALL carry data[7:0]; both bytes SHALL be ACKed.
REQ-023 Write commit:
- o_wr_valid SHALL pulse one i_clk cycle after the SCL falling edge that ends ACK_2.
- o_wr_addr and o_wr_data SHALL update in that same cycle.
- The FSM SHALL then return to BYTE1, so a further byte pair continues as a new write until STOP.
REQ-024 If reg_addr < NREG, the register SHALL be written in the o_wr_valid cycle; otherwise o_wr_valid SHALL still pulse but no register changes.
REQ-025 A committed write to reg_addr 7'h0F with data 9'h000 SHALL clear all registers to 0 in the same cycle (codec soft reset).
REQ-026 In IGNORE, o_sda_oe SHALL stay 0 until START or STOP.
REQ-027 If START/STOP and an SCL edge are detected in the same cycle, START/STOP SHALL take priority.
REQ-028 The block SHALL never drive SDA high; o_sda_oe is the only SDA output.

Reset
REQ-029 On i_rst the block SHALL immediately set: FSM=IDLE, o_sda_oe=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, all registers=0, synchronizers=1.
REQ-030 Reset asserted mid-frame SHALL release SDA immediately; after deassertion the block SHALL ignore the bus until the next START.

Configuration
REQ-031 With I2C_RESP_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow each synchronizer, adding 2 i_clk of latency and rejecting pulses of at most 1 i_clk.
REQ-032 Without I2C_RESP_GLITCH_FILTER_EN, no filter SHALL exist and a 1-cycle pulse SHALL be treated as a real edge.

Verification
REQ-033 START, 0x34, 0x08, 0x15, STOP -> three ACKs; o_wr_valid pulses once with addr=4, data=0x015; o_rd_data at index 4 = 0x015.
REQ-034 START, 0x36 (wrong address) -> no ACK, o_sda_oe stays 0 through STOP, no write, o_busy 1->0.
REQ-035 Write reg 2 = 0x1FF, then START, 0x34, 0x1E, 0x00, STOP -> all registers read 0.
REQ-036 START, 0x34, 0x0C, then repeated START, 0x34, 0x06, 0x79, STOP -> a single write with addr=3, data=0x079.
REQ-037 Assert i_rst while o_sda_oe=1 during ACK_1 -> o_sda_oe=0 the same cycle and no write occurs.
REQ-038 With I2C_RESP_GLITCH_FILTER_EN, a 1-cycle low glitch on SCL mid-bit -> bit count unchanged and the write completes correctly; without the macro, the same stimulus -> frame misaligned, no valid write.

Source files
------------

// File: rtl/i2c_codec_responder_if.sv
// Bus bundle for i2c_codec_responder: the I2C pins plus the write-report
// and register read-back signals. The responder uses the slave modport;
// whatever drives the I2C lines and reads registers uses the master modport.
`timescale 1ns/1ps
interface i2c_codec_responder_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_oe;
  logic       o_wr_valid;
  logic [6:0] o_wr_addr;
  logic [8:0] o_wr_data;
  logic [3:0] i_rd_addr;
  logic [8:0] o_rd_data;
  logic       o_busy;

  modport slave (
    input  i_scl, i_sda, i_rd_addr,
    output o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data, o_rd_data, o_busy
  );

  modport master (
    output i_scl, i_sda, i_rd_addr,
    input  o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data, o_rd_data, o_busy
  );
endinterface

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder for a codec-style 9-bit control register file.
// A frame is START, device address (write), then byte pairs of
// {reg_addr[6:0], data[8]} and data[7:0]; each pair commits one write.
// Optional build macro: I2C_RESP_GLITCH_FILTER_EN adds a 3-sample majority
// filter after each input synchronizer (2 extra i_clk of latency, rejects
// single-cycle pulses). Without it, every synchronized change is an edge.
`timescale 1ns/1ps
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NREG     = 16
) (
  input logic                   i_clk,
  input logic                   i_rst,
  i2c_codec_responder_if.slave  bus
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte1_q, byte1_d;
  logic        commit;

  logic [1:0]  sclSync_q, sdaSync_q;
  logic        sclF, sdaF;
  logic        sclPrev_q, sdaPrev_q;
  logic        sclRise, sclFall, startDet, stopDet;

  logic        wrValid_q;
  logic [6:0]  wrAddr_q;
  logic [8:0]  wrData_q;
  logic [8:0]  regs_q [NREG];

  logic [6:0]  commitAddr;
  logic [8:0]  commitData;
  logic        sdaOe, busy;

  // Two-flop synchronizers; the bus idles high so they reset to 1
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclSync_q <= 2'b11;
      sdaSync_q <= 2'b11;
    end else begin
      sclSync_q <= {sclSync_q[0], bus.i_scl};
      sdaSync_q <= {sdaSync_q[0], bus.i_sda};
    end
  end

`ifdef I2C_RESP_GLITCH_FILTER_EN
  logic [1:0] sclHist_q, sdaHist_q;
  logic       sclFilt_q, sdaFilt_q;

  // Majority of the current and two previous samples swallows 1-cycle pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclHist_q <= 2'b11;
      sdaHist_q <= 2'b11;
      sclFilt_q <= 1'b1;
      sdaFilt_q <= 1'b1;
    end else begin
      sclHist_q <= {sclHist_q[0], sclSync_q[1]};
      sdaHist_q <= {sdaHist_q[0], sdaSync_q[1]};
      sclFilt_q <= (sclSync_q[1] & sclHist_q[0]) | (sclSync_q[1] & sclHist_q[1]) |
                   (sclHist_q[0] & sclHist_q[1]);
      sdaFilt_q <= (sdaSync_q[1] & sdaHist_q[0]) | (sdaSync_q[1] & sdaHist_q[1]) |
                   (sdaHist_q[0] & sdaHist_q[1]);
    end
  end

  assign sclF = sclFilt_q;
  assign sdaF = sdaFilt_q;
`else
  assign sclF = sclSync_q[1];
  assign sdaF = sdaSync_q[1];
`endif

  // Edge-detect stage: remember last cleaned SCL/SDA levels
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclPrev_q <= sclF;
      sdaPrev_q <= sdaF;
    end
  end

  assign sclRise  = sclF & ~sclPrev_q;
  assign sclFall  = ~sclF & sclPrev_q;
  assign startDet = sclF & sclPrev_q & sdaPrev_q & ~sdaF;
  assign stopDet  = sclF & sclPrev_q & ~sdaPrev_q & sdaF;

  // FSM state and frame shift registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      byte1_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      byte1_q  <= byte1_d;
    end
  end

  // Next state: START/STOP override bit handling; bits shift on SCL rise,
  // byte/ACK boundaries advance on SCL fall
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    byte1_d  = byte1_q;
    commit   = 1'b0;
    if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = '0;
    end else if (stopDet) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR, BYTE1, BYTE2: begin
          if (sclRise && bitCnt_q != 4'd8) begin
            shift_d  = {shift_q[6:0], sdaF};
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == 4'd8) begin
            if (state_q == ADDR) begin
              state_d = (shift_q[7:1] == DEV_ADDR && !shift_q[0]) ? ACK_A : IGNORE;
            end else if (state_q == BYTE1) begin
              byte1_d = shift_q;
              state_d = ACK_1;
            end else begin
              state_d = ACK_2;
            end
          end
        end
        ACK_A, ACK_1: begin
          if (sclFall) begin
            state_d  = (state_q == ACK_A) ? BYTE1 : BYTE2;
            bitCnt_d = '0;
          end
        end
        ACK_2: begin
          if (sclFall) begin
            commit   = 1'b1;
            state_d  = BYTE1;
            bitCnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state: pull SDA only in ACK slots; busy while framed
  always_comb begin
    sdaOe = 1'b0;
    busy  = 1'b0;
    if (state_q == ACK_A || state_q == ACK_1 || state_q == ACK_2) sdaOe = 1'b1;
    if (state_q != IDLE) busy = 1'b1;
  end

  assign commitAddr = byte1_q[7:1];
  assign commitData = {byte1_q[0], shift_q};

  // Commit a byte pair: report it, then update the register file
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrValid_q <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      wrValid_q <= commit;
      if (commit) begin
        wrAddr_q <= commitAddr;
        wrData_q <= commitData;
        if (commitAddr == 7'h0F && commitData == 9'h000) begin
          for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (32'(commitAddr) < NREG) begin
          regs_q[commitAddr[AW-1:0]] <= commitData;
        end
      end
    end
  end

  assign bus.o_sda_oe   = sdaOe;
  assign bus.o_busy     = busy;
  assign bus.o_wr_valid = wrValid_q;
  assign bus.o_wr_addr  = wrAddr_q;
  assign bus.o_wr_data  = wrData_q;
  assign bus.o_rd_data  = (32'(bus.i_rd_addr) < NREG) ? regs_q[bus.i_rd_addr[AW-1:0]] : '0;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Testbench for i2c_codec_responder: an I2C master model drives frames while a
// monitor pops expected {addr,data} pairs whenever o_wr_valid pulses.
`timescale 1ns/1ps
module tb_i2c_codec_responder;

   localparam int Q = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclDrv = 1'b1;
   logic sdaDrv = 1'b1;
   logic [3:0] rdAddr = '0;

   int total = 0;
   int bad = 0;
   int oeCount = 0;
   logic [15:0] expQ[$];

   i2c_codec_responder_if bus ();

   assign bus.i_scl     = sclDrv;
   assign bus.i_sda     = sdaDrv & ~bus.o_sda_oe;
   assign bus.i_rd_addr = rdAddr;

   i2c_codec_responder dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   // Scoreboard monitor: every write pulse must match the oldest expectation
   always @(negedge clk) begin
      logic [15:0] e;
      if (bus.o_wr_valid) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected write: got addr=%0h data=%0h required none",
                     bus.o_wr_addr, bus.o_wr_data);
         end else begin
            e = expQ.pop_front();
            if ({bus.o_wr_addr, bus.o_wr_data} != e) begin
               bad++;
               $display("[TB] FAIL write: got addr=%0h data=%0h required addr=%0h data=%0h",
                        bus.o_wr_addr, bus.o_wr_data, e[15:9], e[8:0]);
            end
         end
      end
   end

   // Counts cycles with SDA pulled so quiet windows can be checked
   always @(negedge clk) begin
      if (bus.o_sda_oe) oeCount++;
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string nm, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h required %0h", nm, actual, expected);
      end
   endtask

   task automatic readReg(input int idx, input int expected, input string nm);
      rdAddr = 4'(idx);
      waitClk(1);
      checkOutput(nm, bus.o_rd_data, expected);
   endtask

   task automatic i2cStart();
      sdaDrv = 1'b1; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      sdaDrv = 1'b0; waitClk(Q);
      sclDrv = 1'b0; waitClk(Q);
   endtask

   task automatic i2cStop();
      sdaDrv = 1'b0; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      sdaDrv = 1'b1; waitClk(Q);
   endtask

   // Eight data bits MSB first; optional 1-cycle SCL low glitch in one bit
   task automatic sendBits(input logic [7:0] b, input int glitchBit);
      for (int i = 7; i >= 0; i--) begin
         sdaDrv = b[i];
         waitClk(Q);
         sclDrv = 1'b1;
         if (i == glitchBit) begin
            waitClk(Q);
            @(negedge clk) sclDrv = 1'b0;
            @(negedge clk) sclDrv = 1'b1;
            waitClk(Q - 2);
         end else begin
            waitClk(2 * Q);
         end
         sclDrv = 1'b0;
         waitClk(Q);
      end
   endtask

   // One byte plus its ACK clock, checking whether the responder pulls SDA
   task automatic applyStimulus(input logic [7:0] b, input int expAck, input string nm,
                                input int glitchBit = -1);
      sendBits(b, glitchBit);
      sdaDrv = 1'b1;
      waitClk(Q);
      sclDrv = 1'b1;
      waitClk(Q);
      checkOutput({nm, " ack"}, bus.o_sda_oe, expAck);
      waitClk(Q);
      sclDrv = 1'b0;
      waitClk(Q);
   endtask

   initial begin
      int oeBefore;
      int filt;
`ifdef I2C_RESP_GLITCH_FILTER_EN
      filt = 1;
`else
      filt = 0;
`endif

      // Reset state
      waitClk(3);
      checkOutput("reset oe", bus.o_sda_oe, 0);
      checkOutput("reset busy", bus.o_busy, 0);
      rst = 1'b0;
      waitClk(4);
      checkOutput("idle wr_valid", bus.o_wr_valid, 0);
      checkOutput("idle wr_addr", bus.o_wr_addr, 0);
      checkOutput("idle wr_data", bus.o_wr_data, 0);
      readReg(0, 0, "idle reg0");

      // Basic write: reg 4 = 0x015
      i2cStart();
      checkOutput("busy after start", bus.o_busy, 1);
      expQ.push_back({7'd4, 9'h015});
      applyStimulus(8'h34, 1, "w1 addr");
      applyStimulus(8'h08, 1, "w1 byte1");
      applyStimulus(8'h15, 1, "w1 byte2");
      i2cStop();
      checkOutput("busy after stop", bus.o_busy, 0);
      readReg(4, 9'h015, "w1 reg4");

      // Wrong device address: never pulls SDA, no write
      oeBefore = oeCount;
      i2cStart();
      applyStimulus(8'h36, 0, "wrong addr");
      checkOutput("ignore busy", bus.o_busy, 1);
      applyStimulus(8'h08, 0, "ignore byte1");
      i2cStop();
      checkOutput("ignore oe cycles", oeCount - oeBefore, 0);
      checkOutput("ignore busy after stop", bus.o_busy, 0);

      // Repeated START discards the partial pair
      i2cStart();
      applyStimulus(8'h34, 1, "rs addr");
      applyStimulus(8'h0C, 1, "rs partial byte1");
      i2cStart();
      expQ.push_back({7'd3, 9'h079});
      applyStimulus(8'h34, 1, "rs addr2");
      applyStimulus(8'h06, 1, "rs byte1");
      applyStimulus(8'h79, 1, "rs byte2");
      i2cStop();
      readReg(3, 9'h079, "rs reg3");
      readReg(6, 0, "rs reg6 untouched");

      // reg 2 = 0x1FF, then soft reset clears everything
      i2cStart();
      expQ.push_back({7'd2, 9'h1FF});
      applyStimulus(8'h34, 1, "r2 addr");
      applyStimulus(8'h05, 1, "r2 byte1");
      applyStimulus(8'hFF, 1, "r2 byte2");
      i2cStop();
      readReg(2, 9'h1FF, "r2 reg2");
      i2cStart();
      expQ.push_back({7'h0F, 9'h000});
      applyStimulus(8'h34, 1, "sr addr");
      applyStimulus(8'h1E, 1, "sr byte1");
      applyStimulus(8'h00, 1, "sr byte2");
      i2cStop();
      for (int i = 0; i < 16; i++) readReg(i, 0, $sformatf("soft reset reg%0d", i));

      // Several pairs in one frame, one out of range
      i2cStart();
      expQ.push_back({7'd4, 9'h123});
      expQ.push_back({7'h10, 9'h0AB});
      expQ.push_back({7'd5, 9'h155});
      applyStimulus(8'h34, 1, "mp addr");
      applyStimulus(8'h09, 1, "mp p1 byte1");
      applyStimulus(8'h23, 1, "mp p1 byte2");
      applyStimulus(8'h20, 1, "mp p2 byte1");
      applyStimulus(8'hAB, 1, "mp p2 byte2");
      applyStimulus(8'h0B, 1, "mp p3 byte1");
      applyStimulus(8'h55, 1, "mp p3 byte2");
      i2cStop();
      readReg(4, 9'h123, "mp reg4");
      readReg(5, 9'h155, "mp reg5");
      readReg(0, 0, "mp reg0 not aliased");

      // Reset while pulling SDA in ACK_1
      i2cStart();
      applyStimulus(8'h34, 1, "rst addr");
      sendBits(8'h08, -1);
      sdaDrv = 1'b1;
      waitClk(Q);
      sclDrv = 1'b1;
      waitClk(Q);
      checkOutput("rst ack1 before", bus.o_sda_oe, 1);
      @(negedge clk) rst = 1'b1;
      #1;
      checkOutput("rst oe immediate", bus.o_sda_oe, 0);
      checkOutput("rst busy immediate", bus.o_busy, 0);
      waitClk(3);
      rst = 1'b0;
      waitClk(Q);
      sclDrv = 1'b0;
      waitClk(Q);
      applyStimulus(8'h15, 0, "rst after release");
      i2cStop();
      readReg(4, 0, "rst reg4 cleared");

      // Single-cycle SCL glitch in the first address bit
      i2cStart();
      if (filt == 1) expQ.push_back({7'd4, 9'h02A});
      applyStimulus(8'h34, filt, "gl addr", 7);
      applyStimulus(8'h08, filt, "gl byte1");
      applyStimulus(8'h2A, filt, "gl byte2");
      i2cStop();
      readReg(4, (filt == 1) ? 9'h02A : 0, "gl reg4");

      waitClk(10);
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
